demux32_scatter: RTL and testbench

Sequential 1-to-32 data distributor: the write-side counterpart of the ALU's 32:1 bit selector. Single bits with a 5-bit select address are scattered into a 32-bit assembly register. The collected word is presented on a valid/ready output port once every bit position has been written. The block sits between a serial bit source and the ALU operand registers.

---
 rtl/demux32_scatter_pkg.sv | 22 ++
 rtl/demux32_scatter_if.sv | 46 ++++
 rtl/demux32_scatter_dec5to32.sv | 21 ++
 rtl/demux32_scatter.sv | 108 ++++++++++
 tb/tb_demux32_scatter.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/demux32_scatter_pkg.sv
// ---------------------------------------------------------------------------
// | Module   : demux_pkg                                                    |
// | Desc     : Shared constants and state encoding for demux32_scatter.     |
// | Revision : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  localparam int WIDTH = 32;
  localparam int SEL_W = 5;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/demux32_scatter_if.sv
// ---------------------------------------------------------------------------
// | Module   : demux32_scatter_if                                           |
// | Desc     : Bit-input / word-output bundle; out_par under DEMUX_PARITY_EN|
// | Revision : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

interface demux32_scatter_if;
  import demux_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic             d;
  logic [SEL_W-1:0] sel;
  logic             auto;
  logic             clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] written;
  logic [SEL_W-1:0] ptr;
`ifdef DEMUX_PARITY_EN
  logic             out_par;

  modport master (
    output in_valid, d, sel, auto, clr, out_ready,
    input  in_ready, out_valid, q, written, ptr, out_par
  );
  modport slave (
    input  in_valid, d, sel, auto, clr, out_ready,
    output in_ready, out_valid, q, written, ptr, out_par
  );
`else
  modport master (
    output in_valid, d, sel, auto, clr, out_ready,
    input  in_ready, out_valid, q, written, ptr
  );
  modport slave (
    input  in_valid, d, sel, auto, clr, out_ready,
    output in_ready, out_valid, q, written, ptr
  );
`endif

endinterface

`default_nettype wire

// File: rtl/demux32_scatter_dec5to32.sv
// ---------------------------------------------------------------------------
// | Module   : dec5to32                                                     |
// | Desc     : Combinational 5-bit to 32-bit one-hot decoder.               |
// | Revision : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

module dec5to32
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] onehot
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign onehot[i] = (sel == SEL_W'(i));
  end

endmodule

`default_nettype wire

// File: rtl/demux32_scatter.sv
// ---------------------------------------------------------------------------
// | Module   : demux32_scatter                                              |
// | Desc     : Scatters addressed/auto-indexed bits into a 32-bit word and  |
// |            presents it on valid/ready; DEMUX_PARITY_EN adds out_par.    |
// | Revision : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

module demux32_scatter
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  demux32_scatter_if.slave bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] written_q, written_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic             par_q, par_d;

  logic [SEL_W-1:0] pos;
  logic [WIDTH-1:0] onehot;
  logic             accept;

  assign pos    = bus.auto ? ptr_q : bus.sel;
  assign accept = bus.in_valid && (state_q == FILL);

  dec5to32 u_dec (
    .sel    (pos),
    .onehot (onehot)
  );

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    written_d = written_q;
    ptr_d     = ptr_q;
    par_d     = par_q;
    // clr outranks both the bit accept and the output handshake
    if (bus.clr) begin
      state_d   = FILL;
      q_d       = '0;
      written_d = '0;
      ptr_d     = '0;
      par_d     = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            q_d       = (q_q & ~onehot) | (bus.d ? onehot : '0);
            written_d = written_q | onehot;
            par_d     = par_q ^ (bus.d ^ (|(q_q & onehot)));
            if (bus.auto) begin
              ptr_d = ptr_q + SEL_W'(1);
            end
            if ((written_q | onehot) == ALL_ONES) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_d   = FILL;
            q_d       = '0;
            written_d = '0;
            ptr_d     = '0;
            par_d     = 1'b0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= FILL;
      q_q       <= '0;
      written_q <= '0;
      ptr_q     <= '0;
      par_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      written_q <= written_d;
      ptr_q     <= ptr_d;
      par_q     <= par_d;
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.q         = q_q;
  assign bus.written   = written_q;
  assign bus.ptr       = ptr_q;

`ifdef DEMUX_PARITY_EN
  assign bus.out_par = par_q;
`else
  logic unused_par;
  assign unused_par = par_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux32_scatter.sv
// ---------------------------------------------------------------------------
// | Module   : tb_demux32_scatter                                           |
// | Desc     : Directed table plus sequences for demux32_scatter.           |
// | Revision : 1.0 - initial release                                       |
// ---------------------------------------------------------------------------
`default_nettype none

module tb_demux32_scatter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  demux32_scatter_if bus ();

  demux32_scatter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_valid;
    logic        d;
    logic [4:0]  sel;
    logic        auto_m;
    logic        clr;
    logic        out_ready;
    logic [31:0] exp_q;
    logic [31:0] exp_written;
    logic [4:0]  exp_ptr;
    logic        exp_in_ready;
    logic        exp_out_valid;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic dd, input logic [4:0] s,
                       input logic a, input logic c, input logic r);
    bus.in_valid  = v;
    bus.d         = dd;
    bus.sel       = s;
    bus.auto      = a;
    bus.clr       = c;
    bus.out_ready = r;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " q"}, bus.q, 32'h0);
    check({tag, " written"}, bus.written, 32'h0);
    check({tag, " ptr"}, {27'h0, bus.ptr}, 32'h0);
    check({tag, " in_ready"}, {31'h0, bus.in_ready}, 32'h1);
    check({tag, " out_valid"}, {31'h0, bus.out_valid}, 32'h0);
  endtask

  task automatic auto_fill(input logic [31:0] word, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, word[i], 5'd0, 1'b1, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic handshake(input string tag);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    tick();
    check_idle(tag);
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    vecs[0] = '{1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0001, 5'd1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003, 5'd2, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003, 5'd2, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0, 32'h8000_0001, 32'h8000_0003, 5'd2, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0003, 5'd2, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 5'd0,  1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 32'h0000_0020, 32'h0000_0020, 5'd0, 1'b1, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'd0, 1'b1, 1'b0};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    check_idle("reset");

    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].in_valid, vecs[i].d, vecs[i].sel, vecs[i].auto_m, vecs[i].clr, vecs[i].out_ready);
      tick();
      check($sformatf("vec%0d q", i), bus.q, vecs[i].exp_q);
      check($sformatf("vec%0d written", i), bus.written, vecs[i].exp_written);
      check($sformatf("vec%0d ptr", i), {27'h0, bus.ptr}, {27'h0, vecs[i].exp_ptr});
      check($sformatf("vec%0d in_ready", i), {31'h0, bus.in_ready}, {31'h0, vecs[i].exp_in_ready});
      check($sformatf("vec%0d out_valid", i), {31'h0, bus.out_valid}, {31'h0, vecs[i].exp_out_valid});
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // auto fill: completion appears exactly after the 32nd accept
    w = 32'hA5A5_0F0F;
    auto_fill(w, 31);
    check("auto31 out_valid", {31'h0, bus.out_valid}, 32'h0);
    check("auto31 ptr", {27'h0, bus.ptr}, 32'd31);
    drive(1'b1, w[31], 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    check("auto q", bus.q, 32'hA5A5_0F0F);
    check("auto out_valid", {31'h0, bus.out_valid}, 32'h1);
    check("auto in_ready", {31'h0, bus.in_ready}, 32'h0);
    check("auto ptr", {27'h0, bus.ptr}, 32'h0);
`ifdef DEMUX_PARITY_EN
    check("auto out_par", {31'h0, bus.out_par}, 32'h0);
`endif
    handshake("auto hs");

    // addressed fill with overwrite of bit 7 before the final position
    for (int i = 0; i < 31; i++) begin
      drive(1'b1, 1'b1, 5'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b1, 1'b0, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    check("addr ovw q", bus.q, 32'h7FFF_FF7F);
    check("addr ovw written", bus.written, 32'h7FFF_FFFF);
    check("addr ovw out_valid", {31'h0, bus.out_valid}, 32'h0);
    drive(1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b0);
    tick();
    check("addr q", bus.q, 32'hFFFF_FF7F);
    check("addr written", bus.written, 32'hFFFF_FFFF);
    check("addr out_valid", {31'h0, bus.out_valid}, 32'h1);
`ifdef DEMUX_PARITY_EN
    check("addr out_par", {31'h0, bus.out_par}, 32'h1);
`endif

    // back-pressure: bits offered in HOLD must not land
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      check($sformatf("bp%0d q", i), bus.q, 32'hFFFF_FF7F);
      check($sformatf("bp%0d written", i), bus.written, 32'hFFFF_FFFF);
      check($sformatf("bp%0d ptr", i), {27'h0, bus.ptr}, 32'h0);
      check($sformatf("bp%0d in_ready", i), {31'h0, bus.in_ready}, 32'h0);
      check($sformatf("bp%0d out_valid", i), {31'h0, bus.out_valid}, 32'h1);
    end
    drive(1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b1);
    tick();
    check_idle("bp release");
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);

    // clr in the same cycle as the completing accept
    auto_fill(32'hFFFF_FFFF, 31);
    drive(1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
    tick();
    check_idle("clr prio");
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("clr after out_valid", {31'h0, bus.out_valid}, 32'h0);

    // reset mid-word, then a fresh word
    auto_fill(32'hFFFF_FFFF, 10);
    check("mid written", bus.written, 32'h0000_03FF);
    check("mid ptr", {27'h0, bus.ptr}, 32'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("mid reset");
    w = 32'h1234_5678;
    auto_fill(w, 32);
    check("fresh q", bus.q, 32'h1234_5678);
    check("fresh out_valid", {31'h0, bus.out_valid}, 32'h1);
`ifdef DEMUX_PARITY_EN
    check("fresh out_par", {31'h0, bus.out_par}, {31'h0, ^w});
`endif
    handshake("fresh hs");

    // mixed: 16 auto writes then addressed 16..31
    auto_fill(32'h0000_FFFF, 16);
    check("mixed ptr16", {27'h0, bus.ptr}, 32'd16);
    for (int i = 16; i < 32; i++) begin
      check($sformatf("mixed pre%0d out_valid", i), {31'h0, bus.out_valid}, 32'h0);
      drive(1'b1, 1'(i & 1), 5'(i), 1'b0, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    check("mixed q", bus.q, 32'hAAAA_FFFF);
    check("mixed out_valid", {31'h0, bus.out_valid}, 32'h1);
    check("mixed ptr", {27'h0, bus.ptr}, 32'd16);
    handshake("mixed hs");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
